// File: rtl/fpnew_ctrl_pkg.sv
// Shared types and constants for the FPNew issue/collect wrapper.
//   status_t     : IEEE exception flags {NV,DZ,OF,UF,NX}
//   resp_entry_t : one buffered FPU response {result, status, tag} at the default widths
package fpnew_ctrl_pkg;

    localparam int unsigned STATUS_W       = 5;
    localparam int unsigned PKG_FLEN       = 16;
    localparam int unsigned PKG_TAG_WIDTH  = 2;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } status_t;

    typedef struct packed {
        logic [PKG_FLEN-1:0]      result;
        status_t                  status;
        logic [PKG_TAG_WIDTH-1:0] tag;
    } resp_entry_t;

    // Sticky accumulation of exception flags.
    function automatic status_t status_merge(status_t acc, status_t inc);
        return status_t'(acc | inc);
    endfunction

endpackage

// File: rtl/fpnew_resp_fifo.sv
// Generic registered FIFO (no write-to-read bypass).
// Ports:
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   flush_i       : empties the FIFO on the next edge
//   push_i/wdata_i: write request and data
//   pop_i         : read request (ignored when empty)
//   rdata_o       : head entry
//   full_o/empty_o: occupancy status
//   wr_o          : a write is actually taken this cycle
//   drop_o        : push while full without a pop; the data is discarded
module fpnew_resp_fifo
    import fpnew_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             wr_o,
    output logic             drop_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit; full/empty are decided on its difference.
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_pop;

    assign empty_o = (r_wptr == r_rptr);
    assign full_o  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop   = pop_i & ~empty_o;
    // At full, a same-cycle pop frees the slot the write lands in.
    assign wr_o    = push_i & (~full_o | w_pop);
    assign drop_o  = push_i & full_o & ~w_pop;
    assign rdata_o = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (flush_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (wr_o) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_o) begin
            r_mem[r_wptr[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/fpnew_issue_collect.sv
// Issue/collect wrapper around the FPNew blackbox.
// Requests are forwarded to the FPU under a credit limit of DEPTH; every FPU
// result is captured in a DEPTH-entry FIFO so the FPU output never stalls.
// Ports:
//   req_*      : upstream request handshake and payload
//   fpu_*      : FPU-facing request passthrough, flush and result capture
//   resp_*     : downstream response handshake (FIFO head)
//   flush_i    : discard all in-flight and buffered work
//   clr_flags_i: clear sticky exception flags
//   flags_o    : sticky OR of collected status
//   overflow_o : sticky, a result arrived with the FIFO full and was dropped
//   inflight_o : credits in use
module fpnew_issue_collect
    import fpnew_ctrl_pkg::*;
#(
    parameter int unsigned FLEN      = 16,
    parameter int unsigned TAG_WIDTH = 2,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned OP_W      = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic [3*FLEN-1:0]            req_operands_i,
    input  logic [OP_W-1:0]              req_op_i,
    input  logic                         req_op_mod_i,
    input  logic [2:0]                   req_rnd_i,
    input  logic [TAG_WIDTH-1:0]         req_tag_i,
    output logic                         fpu_in_valid_o,
    input  logic                         fpu_in_ready_i,
    output logic [3*FLEN-1:0]            fpu_operands_o,
    output logic [OP_W-1:0]              fpu_op_o,
    output logic                         fpu_op_mod_o,
    output logic [2:0]                   fpu_rnd_o,
    output logic [TAG_WIDTH-1:0]         fpu_tag_o,
    output logic                         fpu_flush_o,
    input  logic                         fpu_out_valid_i,
    output logic                         fpu_out_ready_o,
    input  logic [FLEN-1:0]              fpu_result_i,
    input  logic [4:0]                   fpu_status_i,
    input  logic [TAG_WIDTH-1:0]         fpu_tag_i,
    output logic                         resp_valid_o,
    input  logic                         resp_ready_i,
    output logic [FLEN-1:0]              resp_result_o,
    output logic [4:0]                   resp_status_o,
    output logic [TAG_WIDTH-1:0]         resp_tag_o,
    input  logic                         flush_i,
    input  logic                         clr_flags_i,
    output logic [4:0]                   flags_o,
    output logic                         overflow_o,
    output logic [$clog2(DEPTH+1)-1:0]   inflight_o
);

    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned ENTRY_W = FLEN + STATUS_W + TAG_WIDTH;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [CNT_W-1:0]   r_cnt;
    status_t            r_flags;
    logic               r_overflow;

    logic               w_open;
    logic               w_issue;
    logic               w_push;
    logic               w_pop;
    logic               w_empty;
    logic               w_full;
    logic               w_wr;
    logic               w_drop;
    logic [ENTRY_W-1:0] w_wdata;
    logic [ENTRY_W-1:0] w_rdata;
    status_t            w_status;

    // Gate on the registered count only, so resp_ready_i never reaches req_ready_o.
    assign w_open         = (r_cnt < CNT_MAX) & ~flush_i & ~rst_i;
    assign fpu_in_valid_o = req_valid_i & w_open;
    assign req_ready_o    = fpu_in_ready_i & w_open;
    assign w_issue        = fpu_in_valid_o & fpu_in_ready_i;

    assign fpu_operands_o = req_operands_i;
    assign fpu_op_o       = req_op_i;
    assign fpu_op_mod_o   = req_op_mod_i;
    assign fpu_rnd_o      = req_rnd_i;
    assign fpu_tag_o      = req_tag_i;
    assign fpu_flush_o    = flush_i;
    assign fpu_out_ready_o = ~rst_i;

    // A result landing in the flush cycle is discarded.
    assign w_push   = fpu_out_valid_i & ~flush_i;
    assign w_wdata  = {fpu_result_i, fpu_status_i, fpu_tag_i};
    assign w_status = status_t'(fpu_status_i);
    assign resp_valid_o = ~w_empty;
    assign w_pop        = resp_valid_o & resp_ready_i;

    fpnew_resp_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_resp_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (w_push),
        .wdata_i (w_wdata),
        .pop_i   (resp_ready_i),
        .rdata_o (w_rdata),
        .full_o  (w_full),
        .empty_o (w_empty),
        .wr_o    (w_wr),
        .drop_o  (w_drop)
    );

    assign resp_result_o = w_rdata[ENTRY_W-1 -: FLEN];
    assign resp_status_o = w_rdata[TAG_WIDTH +: STATUS_W];
    assign resp_tag_o    = w_rdata[TAG_WIDTH-1:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (flush_i) begin
            r_cnt <= '0;
        end else if (w_issue && !w_pop) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (!w_issue && w_pop) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_flags <= '0;
        end else if (clr_flags_i) begin
            r_flags <= w_wr ? w_status : status_t'('0);
        end else if (w_wr) begin
            r_flags <= status_merge(r_flags, w_status);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_overflow <= 1'b0;
        end else begin
            // Unreachable while the FPU honours the credit limit.
            assert (!w_drop) else $error("fpnew_issue_collect: result dropped, response FIFO full");
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign flags_o    = r_flags;
    assign overflow_o = r_overflow;
    assign inflight_o = r_cnt;

endmodule

// File: tb/tb_fpnew_issue_collect.sv
module tb_fpnew_issue_collect;

    localparam int unsigned FL = 16;
    localparam int unsigned TW = 2;
    localparam int unsigned OW = 4;
    localparam logic [OW-1:0] OP_ADD = 4'd0;
    localparam logic [OW-1:0] OP_DIV = 4'd3;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [3*FL-1:0] req_operands;
    logic [OW-1:0] req_op;
    logic          req_op_mod;
    logic [2:0]    req_rnd;
    logic [TW-1:0] req_tag;
    logic          fpu_in_valid;
    logic          fpu_in_ready;
    logic [3*FL-1:0] fpu_operands;
    logic [OW-1:0] fpu_op;
    logic          fpu_op_mod;
    logic [2:0]    fpu_rnd;
    logic [TW-1:0] fpu_tag;
    logic          fpu_flush;
    logic          fpu_out_ready;
    logic          resp_valid;
    logic          resp_ready;
    logic [FL-1:0] resp_result;
    logic [4:0]    resp_status;
    logic [TW-1:0] resp_tag;
    logic          flush;
    logic          clr_flags;
    logic [4:0]    flags;
    logic          overflow;
    logic [2:0]    inflight;

    // Two-stage FPU stand-in
    logic          s1_v, s2_v;
    logic [20:0]   s1_rs, s2_rs;
    logic [TW-1:0] s1_tag, s2_tag;

    int n_vec = 0;
    int n_err = 0;
    int n_resp = 0;
    int cyc = 0;
    logic [22:0] sb[$];
    int pop_cycles[$];

    always #5 clk = ~clk;

    fpnew_issue_collect dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_operands_i  (req_operands),
        .req_op_i        (req_op),
        .req_op_mod_i    (req_op_mod),
        .req_rnd_i       (req_rnd),
        .req_tag_i       (req_tag),
        .fpu_in_valid_o  (fpu_in_valid),
        .fpu_in_ready_i  (fpu_in_ready),
        .fpu_operands_o  (fpu_operands),
        .fpu_op_o        (fpu_op),
        .fpu_op_mod_o    (fpu_op_mod),
        .fpu_rnd_o       (fpu_rnd),
        .fpu_tag_o       (fpu_tag),
        .fpu_flush_o     (fpu_flush),
        .fpu_out_valid_i (s2_v),
        .fpu_out_ready_o (fpu_out_ready),
        .fpu_result_i    (s2_rs[20:5]),
        .fpu_status_i    (s2_rs[4:0]),
        .fpu_tag_i       (s2_tag),
        .resp_valid_o    (resp_valid),
        .resp_ready_i    (resp_ready),
        .resp_result_o   (resp_result),
        .resp_status_o   (resp_status),
        .resp_tag_o      (resp_tag),
        .flush_i         (flush),
        .clr_flags_i     (clr_flags),
        .flags_o         (flags),
        .overflow_o      (overflow),
        .inflight_o      (inflight)
    );

    // {result, status}; status taken from c[4:0] so tests can inject flags.
    function automatic logic [20:0] fpu_model(input logic [OW-1:0] op, input logic [47:0] ops);
        logic [15:0] a, b, r;
        logic [4:0]  st;
        a  = ops[15:0];
        b  = ops[31:16];
        st = ops[36:32];
        if (op == OP_DIV) begin
            if (b == 16'h0000) begin
                r  = 16'h7C00;
                st = st | 5'b01000;
            end else begin
                r = a ^ b;
            end
        end else if (a == 16'h3C00 && b == 16'h4000) begin
            r = 16'h4200;
        end else if (a == 16'h3C00 && b == 16'h3C00) begin
            r = 16'h4000;
        end else begin
            r = a + b;
        end
        return {r, st};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
        end else if (fpu_flush) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
        end else begin
            s1_v   <= fpu_in_valid & fpu_in_ready;
            s1_rs  <= fpu_model(fpu_op, fpu_operands);
            s1_tag <= fpu_tag;
            s2_v   <= s1_v;
            s2_rs  <= s1_rs;
            s2_tag <= s1_tag;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: push on accepted request, pop and compare on accepted response.
    always @(negedge clk) begin
        logic [22:0] e;
        cyc++;
        if (rst || flush) begin
            sb.delete();
        end else begin
            if (req_valid && req_ready) begin
                sb.push_back({fpu_model(req_op, req_operands), req_tag});
            end
            if (resp_valid && resp_ready) begin
                pop_cycles.push_back(cyc);
                n_resp++;
                if (sb.size() == 0) begin
                    check("resp_expected", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    check("resp_result", 32'(resp_result), 32'(e[22:7]));
                    check("resp_status", 32'(resp_status), 32'(e[6:2]));
                    check("resp_tag", 32'(resp_tag), 32'(e[1:0]));
                end
            end
        end
    end

    task automatic set_req(input logic [OW-1:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [TW-1:0] tag);
        req_op       = op;
        req_operands = {c, b, a};
        req_tag      = tag;
        req_rnd      = {1'b0, tag};
        req_op_mod   = tag[0];
    endtask

    task automatic single(input logic [OW-1:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [TW-1:0] tag, input string name);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        set_req(op, a, b, c, tag);
        req_valid  = 1'b1;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (resp_valid) got = 1'b1;
        end
        check({name, "_resp_arrived"}, 32'(got), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit got;
        int k, stall, idx, guard, seen, resp0;

        rst = 1'b1; req_valid = 1'b1; fpu_in_ready = 1'b1; resp_ready = 1'b0;
        flush = 1'b0; clr_flags = 1'b0;
        set_req(OP_ADD, 16'h3C00, 16'h4000, 16'h0000, 2'd1);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_fpu_in_valid", 32'(fpu_in_valid), 0);
        check("rst_fpu_out_ready", 32'(fpu_out_ready), 0);
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_flags", 32'(flags), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_inflight", 32'(inflight), 0);
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        check("fpu_out_ready", 32'(fpu_out_ready), 1);

        // Single ADD, latency 2 FPU
        @(posedge clk); #1;
        set_req(OP_ADD, 16'h3C00, 16'h4000, 16'h0000, 2'd1);
        req_valid = 1'b1; resp_ready = 1'b1;
        @(negedge clk);
        check("t1_req_ready", 32'(req_ready), 1);
        check("t1_fpu_in_valid", 32'(fpu_in_valid), 1);
        check("t1_fpu_operands", 32'(fpu_operands[31:0]), 32'h4000_3C00);
        check("t1_fpu_tag", 32'(fpu_tag), 1);
        check("t1_fpu_rnd", 32'(fpu_rnd), 1);
        check("t1_fpu_op_mod", 32'(fpu_op_mod), 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        got = 1'b0; k = 0;
        for (int i = 1; i <= 20 && !got; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                got = 1'b1;
                k = i;
            end
        end
        check("t1_resp_arrived", 32'(got), 1);
        check("t1_latency", 32'(k), 3);
        check("t1_result", 32'(resp_result), 32'h4200);
        check("t1_tag", 32'(resp_tag), 1);
        check("t1_flags", 32'(flags), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_inflight_after_pop", 32'(inflight), 0);
        check("t1_resp_valid_after_pop", 32'(resp_valid), 0);

        // Credit limit
        resp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            set_req(OP_ADD, 16'h1000 + 16'(i), 16'h0100, 16'h0000, TW'(i));
            req_valid = 1'b1;
            @(negedge clk);
            check("t2_req_ready", 32'(req_ready), (i < 4) ? 32'd1 : 32'd0);
        end
        repeat (4) @(negedge clk);
        check("t2_inflight_full", 32'(inflight), 4);
        check("t2_resp_valid", 32'(resp_valid), 1);
        check("t2_blocked", 32'(req_ready), 0);
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(negedge clk);
        check("t2_ready_during_pop", 32'(req_ready), 0);
        @(posedge clk); #1;
        resp_ready = 1'b0;
        @(negedge clk);
        check("t2_ready_after_pop", 32'(req_ready), 1);
        check("t2_inflight_after_pop", 32'(inflight), 3);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("t2_inflight_refill", 32'(inflight), 4);
        @(posedge clk); #1;
        resp_ready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (inflight == 0) got = 1'b1;
        end
        check("t2_drained", 32'(got), 1);

        // Streaming
        pop_cycles.delete();
        stall = 0; idx = 0; guard = 0;
        while (idx < 20 && guard < 100) begin
            @(posedge clk); #1;
            set_req(OP_ADD, 16'h2000 + 16'(idx), 16'h0010, 16'h0000, TW'(idx));
            req_valid = 1'b1;
            @(negedge clk);
            if (req_ready) idx++;
            else stall++;
            guard++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("t3_issued", 32'(idx), 20);
        check("t3_stalls", 32'(stall), 0);
        for (int i = 0; i < 50 && pop_cycles.size() < 20; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        check("t3_resp_count", 32'(pop_cycles.size()), 20);
        if (pop_cycles.size() >= 20) begin
            check("t3_no_bubbles", 32'(pop_cycles[19] - pop_cycles[0]), 19);
        end
        check("t3_overflow", 32'(overflow), 0);

        // Flags
        check("t4_flags_init", 32'(flags), 0);
        single(OP_DIV, 16'h3C00, 16'h0000, 16'h0000, 2'd2, "t4_div");
        check("t4_flags_dz", 32'(flags), 32'b01000);
        single(OP_ADD, 16'h3C00, 16'h3C00, 16'h0000, 2'd0, "t4_clean");
        check("t4_flags_sticky", 32'(flags), 32'b01000);
        @(posedge clk); #1;
        set_req(OP_ADD, 16'h3C00, 16'h3C00, 16'h0001, 2'd3);
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        clr_flags = 1'b1;            // lines up with the NX result write
        @(posedge clk); #1;
        clr_flags = 1'b0;
        @(negedge clk);
        check("t4_clr_with_write", 32'(flags), 32'b00001);
        @(posedge clk); #1;
        clr_flags = 1'b1;
        @(posedge clk); #1;
        clr_flags = 1'b0;
        @(negedge clk);
        check("t4_clr_alone", 32'(flags), 0);

        // Flush: op0 in FIFO, op1 at FPU output, op2 in FPU stage 1
        resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            set_req(OP_ADD, 16'h0100, 16'h0200 + 16'(i), (i == 0) ? 16'h0002 :
                    ((i == 1) ? 16'h0010 : 16'h0004), TW'(i));
            req_valid = 1'b1;
        end
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        check("t5_fifo_before_flush", 32'(resp_valid), 1);
        check("t5_inflight_before_flush", 32'(inflight), 3);
        check("t5_fpu_flush", 32'(fpu_flush), 1);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("t5_resp_valid", 32'(resp_valid), 0);
        check("t5_inflight", 32'(inflight), 0);
        resp_ready = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        check("t5_no_late_resp", 32'(seen), 0);
        check("t5_flags_kept", 32'(flags), 32'b00010);

        // Asynchronous reset mid-stream
        resp_ready = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            set_req(OP_ADD, 16'h0001, 16'h0002, 16'h0000, 2'd0);
            req_valid = 1'b1;
        end
        @(posedge clk); #1;
        check("t6_pre_resp_valid", 32'(resp_valid), 1);
        check("t6_pre_inflight", 32'(inflight), 3);
        #2;
        rst = 1'b1;
        #1;
        check("t6_req_ready", 32'(req_ready), 0);
        check("t6_fpu_in_valid", 32'(fpu_in_valid), 0);
        check("t6_fpu_out_ready", 32'(fpu_out_ready), 0);
        check("t6_resp_valid", 32'(resp_valid), 0);
        check("t6_inflight", 32'(inflight), 0);
        check("t6_flags", 32'(flags), 0);
        check("t6_overflow", 32'(overflow), 0);
        req_valid = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        resp0 = n_resp;
        single(OP_ADD, 16'h3C00, 16'h4000, 16'h0000, 2'd1, "t6_after_reset");
        check("t6_resp_count", 32'(n_resp - resp0), 1);
        check("t6_inflight_end", 32'(inflight), 0);
        check("end_overflow", 32'(overflow), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
